// File: rtl/dqnt.sv
// JPEG inverse quantizer: signed 8-bit coefficient times the Q50 luminance entry for its
// raster position, emitted as float32 (or sign-extended int16) with a fixed four-cycle latency.
module dqnt #(
  parameter int FLOAT_OUT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        din_sob,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        dout_last
);

  // Handshake: din is taken on every cycle din_valid is high (no ready, no backpressure);
  // dout is meaningful only while dout_valid is high and holds its last value otherwise.

  localparam logic [7:0] Q_TAB [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  logic [5:0] idx;
  logic [5:0] s_idx;

  assign s_idx = din_sob ? 6'd0 : idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= 6'd0;
    end else if (din_valid) begin
      idx <= s_idx + 6'd1;
    end
  end

  // S1: capture sample and its table entry
  logic       v1, l1;
  logic [7:0] d1, q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= din_valid;
      l1 <= din_valid && (s_idx == 6'd63);
    end
    d1 <= din;
    q1 <= Q_TAB[s_idx];
  end

  // S2: product always fits 16 bits (-128*121 .. 127*121)
  logic               v2, l2;
  logic signed [15:0] p2;
  logic signed [15:0] a_ext, b_ext;

  assign a_ext = {{8{d1[7]}}, d1};
  assign b_ext = {8'd0, q1};

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      v2 <= v1;
      l2 <= l1;
    end
    p2 <= a_ext * b_ext;
  end

  // S3: sign/magnitude split and leading-one position
  logic [14:0] m_c;
  logic [3:0]  e_c;
  logic [15:0] neg_p2;

  assign neg_p2 = -p2;

  always_comb begin
    m_c = p2[15] ? neg_p2[14:0] : p2[14:0];
    e_c = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (m_c[i]) e_c = 4'(i);
    end
  end

  logic               v3, l3, s3, z3;
  logic [14:0]        m3;
  logic [3:0]         e3;
  logic signed [15:0] p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      l3 <= 1'b0;
    end else begin
      v3 <= v2;
      l3 <= l2;
    end
    s3 <= p2[15];
    z3 <= (m_c == 15'd0);
    m3 <= m_c;
    e3 <= e_c;
    p3 <= p2;
  end

  // S4: the shift pushes the leading one out of the 23-bit field, leaving the fraction
  logic [22:0] mant;
  logic [7:0]  expo;
  logic [31:0] f_word;
  logic [31:0] i_word;
  logic [31:0] o_word;

  assign mant   = {8'd0, m3} << (5'd23 - {1'b0, e3});
  assign expo   = 8'd127 + {4'd0, e3};
  assign f_word = z3 ? 32'h0000_0000 : {s3, expo, mant};
  assign i_word = {{16{p3[15]}}, p3};
  assign o_word = (FLOAT_OUT != 0) ? f_word : i_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= 32'h0000_0000;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= v3;
      dout_last  <= v3 && l3;
      if (v3) dout <= o_word;
    end
  end

endmodule

// File: tb/tb_dqnt.sv
// Scoreboard bench for dqnt: driver pushes expected words, a negedge monitor pops and compares.
module tb_dqnt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        din_sob = 1'b0;
  logic [31:0] dout, dout_i;
  logic        dout_valid, dout_valid_i;
  logic        dout_last, dout_last_i;

  always #5 clk = ~clk;

  dqnt #(.FLOAT_OUT(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sob(din_sob),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last)
  );

  dqnt #(.FLOAT_OUT(0)) dut_int (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_sob(din_sob),
    .dout(dout_i), .dout_valid(dout_valid_i), .dout_last(dout_last_i)
  );

  typedef struct packed {
    logic [31:0] f;
    logic [31:0] i;
    logic        last;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] cyc = 32'd0;
  int tb_idx = 0;

  logic [7:0] q_ref [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99
  };

  always @(posedge clk) cyc <= cyc + 32'd1;

  // float32 reference via the simulator's double encoding (values are small exact integers)
  function automatic logic [31:0] to_f32(input int v);
    real r;
    logic [63:0] b;
    logic [10:0] e11;
    if (v == 0) return 32'h0;
    r = v;
    b = $realtobits(r);
    e11 = b[62:52] - 11'd896;
    return {b[63], e11[7:0], b[51:29]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic sob, input bit push,
                      input bit hand, input logic [31:0] hf, input logic [31:0] hi);
    int sidx, p;
    exp_t e;
    sidx = sob ? 0 : tb_idx;
    tb_idx = (sidx + 1) % 64;
    p = $signed(d) * int'(q_ref[sidx]);
    e.f = hand ? hf : to_f32(p);
    e.i = hand ? hi : p;
    e.last = (sidx == 63);
    e.cyc = cyc + 32'd4;
    din = d;
    din_sob = sob;
    din_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sob = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got dout %h with empty queue, expected no output", dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dout_float", dout, e.f);
          check("dout_int", dout_i, e.i);
          check("dout_last", {31'd0, dout_last}, {31'd0, e.last});
          check("valid_int", {31'd0, dout_valid_i}, 32'd1);
          check("out_cycle", cyc, e.cyc);
        end
      end else begin
        check("last_idle", {31'd0, dout_last}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_last", {31'd0, dout_last}, 32'd0);
    @(posedge clk);
    #1;

    // basic products, sign and zero
    send(8'h05, 1'b1, 1'b1, 1'b1, 32'h42A00000, 32'd80);
    send(8'hFD, 1'b0, 1'b1, 1'b1, 32'hC2040000, 32'hFFFFFFDF);
    send(8'h00, 1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00000000);
    idle(6);

    // full table sweep, back to back, then wrap to index 0
    for (int i = 0; i < 64; i++) begin
      if (i == 63) send(8'h01, 1'b0, 1'b1, 1'b1, 32'h42C60000, 32'd99);
      else         send(8'h01, i == 0, 1'b1, 1'b0, 32'h0, 32'h0);
    end
    send(8'h01, 1'b0, 1'b1, 1'b1, 32'h41800000, 32'd16);
    idle(6);

    // most negative product at index 53
    send(8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i < 53; i++) send(8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    send(8'h80, 1'b0, 1'b1, 1'b1, 32'hC6720000, 32'hFFFFC380);
    idle(6);

    // two blocks with random gaps; mid-block sob from the previous test restarts numbering
    for (int i = 0; i < 128; i++) begin
      idle($urandom_range(0, 2));
      send(8'($urandom_range(0, 255)), i == 0, 1'b1, 1'b0, 32'h0, 32'h0);
    end
    idle(8);

    // reset with three samples in flight: nothing may emerge, numbering restarts
    send(8'h11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    send(8'h22, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    send(8'h33, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tb_idx = 0;
    idle(8);
    send(8'h02, 1'b0, 1'b1, 1'b1, 32'h42000000, 32'd32);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    idle(2);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
